scan_capture_unit: RTL and testbench

//  Downstream of the scan-chain control unit: deserializes its MSB-first serial scan_chain stream

---
 rtl/scan_capture_unit.sv | 156 +++++++++++++++
 tb/tb_scan_capture_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_capture_unit.sv
//==============================================================================
// Module   : scan_capture_unit
// Purpose  : Deserializes the MSB-first serial scan_chain stream into W-bit
//            words. Completed words are held in a one-entry output buffer
//            with a valid/ready handshake. Aborted partial words and words
//            lost to a full buffer are flagged.
// Ports    : CLK, RST_N (async active-low)
//            scan_enable, scan_shift_feedback, scan_chain : serial input side
//            word_ready / word_valid / word_out           : output handshake
//            shift_busy    : partial word in the shift register
//            partial_abort : 1-cycle pulse on aborted partial word
//            drop_cnt      : saturating count of words dropped on full buffer
// Option   : SCAN_CAPTURE_HAMMING_EN adds hamming_dist / hamming_acc, which
//            track the bit distance between consecutive loaded words.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module scan_capture_unit #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      scan_enable,
  input  logic                      scan_shift_feedback,
  input  logic                      scan_chain,
  input  logic                      word_ready,
  output logic [W-1:0]              word_out,
  output logic                      word_valid,
  output logic                      shift_busy,
  output logic                      partial_abort,
  output logic [CNT_W-1:0]          drop_cnt
`ifdef SCAN_CAPTURE_HAMMING_EN
  ,
  output logic [$clog2(W+1)-1:0]    hamming_dist,
  output logic [CNT_W-1:0]          hamming_acc
`endif
);

  localparam int BCW = $clog2(W);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_SHIFT = 1'b1;

  logic [0:0]     r_state;
  logic [BCW-1:0] r_bit_cnt;
  logic [W-1:0]   r_sreg;

  logic           w_accept;
  logic           w_complete;
  logic [W-1:0]   w_next_word;
  logic           w_load;
  logic           w_drop;

  assign w_accept    = scan_enable & scan_shift_feedback;
  assign w_complete  = w_accept && (r_bit_cnt == BCW'(W-1));
  // Completed word includes the bit arriving this cycle.
  assign w_next_word = {r_sreg[W-2:0], scan_chain};
  // Buffer can take a new word if empty or being drained this same cycle.
  assign w_load      = w_complete & (~word_valid | word_ready);
  assign w_drop      = w_complete & word_valid & ~word_ready;

  assign shift_busy  = (r_state == c_SHIFT);

  //--------------------------------------------------------------------------
  // Shift register and bit counter
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= c_IDLE;
      r_bit_cnt     <= '0;
      r_sreg        <= '0;
      partial_abort <= 1'b0;
    end else begin
      partial_abort <= 1'b0;
      if (!scan_enable) begin
        // SHIFT state is exactly bit_cnt in 1..W-1, so this is the abort case.
        if (r_state == c_SHIFT) begin
          partial_abort <= 1'b1;
        end
        r_state   <= c_IDLE;
        r_bit_cnt <= '0;
        r_sreg    <= '0;
      end else if (w_accept) begin
        if (w_complete) begin
          r_state   <= c_IDLE;
          r_bit_cnt <= '0;
          r_sreg    <= '0;
        end else begin
          r_state   <= c_SHIFT;
          r_bit_cnt <= r_bit_cnt + BCW'(1);
          r_sreg    <= w_next_word;
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // One-entry output buffer and drop counter
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (w_load) begin
        word_out   <= w_next_word;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (w_drop && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SCAN_CAPTURE_HAMMING_EN
  //--------------------------------------------------------------------------
  // Hamming distance between consecutive loaded words. word_out always holds
  // the previously loaded word (0 after reset), so it serves as the reference.
  //--------------------------------------------------------------------------
  localparam int HW = $clog2(W+1);

  logic [W-1:0]   w_diff;
  logic [HW-1:0]  w_pop;
  logic [CNT_W:0] w_acc_sum;

  assign w_diff = w_next_word ^ word_out;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++) begin
      w_pop = w_pop + HW'(w_diff[i]);
    end
  end

  assign w_acc_sum = {1'b0, hamming_acc} + (CNT_W+1)'(w_pop);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hamming_dist <= '0;
      hamming_acc  <= '0;
    end else if (w_load) begin
      hamming_dist <= w_pop;
      hamming_acc  <= w_acc_sum[CNT_W] ? {CNT_W{1'b1}} : w_acc_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_scan_capture_unit.sv
//==============================================================================
// Module   : tb_scan_capture_unit
// Purpose  : Self-checking bench for scan_capture_unit. Expected words are
//            queued as they are shifted in and compared when handed off.
// Option   : SCAN_CAPTURE_HAMMING_EN enables the Hamming output checks.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_scan_capture_unit;

  localparam int W     = 16;
  localparam int CNT_W = 16;

  logic             CLK;
  logic             RST_N;
  logic             scan_enable;
  logic             scan_shift_feedback;
  logic             scan_chain;
  logic             word_ready;
  logic [W-1:0]     word_out;
  logic             word_valid;
  logic             shift_busy;
  logic             partial_abort;
  logic [CNT_W-1:0] drop_cnt;
`ifdef SCAN_CAPTURE_HAMMING_EN
  logic [$clog2(W+1)-1:0] hamming_dist;
  logic [CNT_W-1:0]       hamming_acc;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] sb_q[$];

  scan_capture_unit #(.W(W), .CNT_W(CNT_W)) dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .scan_enable         (scan_enable),
    .scan_shift_feedback (scan_shift_feedback),
    .scan_chain          (scan_chain),
    .word_ready          (word_ready),
    .word_out            (word_out),
    .word_valid          (word_valid),
    .shift_busy          (shift_busy),
    .partial_abort       (partial_abort),
    .drop_cnt            (drop_cnt)
`ifdef SCAN_CAPTURE_HAMMING_EN
    ,
    .hamming_dist        (hamming_dist),
    .hamming_acc         (hamming_acc)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Shift the first nbits of w (MSB first), with gap idle cycles after each bit.
  task automatic shift_bits(input logic [W-1:0] w, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      scan_enable         = 1'b1;
      scan_shift_feedback = 1'b1;
      scan_chain          = w[W-1-i];
      tick();
      scan_shift_feedback = 1'b0;
      if (i != nbits - 1) begin
        repeat (gap) tick();
      end
    end
  endtask

  // Output-side monitor: a transfer occurs at the next edge when valid & ready.
  always @(negedge CLK) begin
    if (RST_N && word_valid && word_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_word", 32'(sb_q.size()), 32'd1);
      end else begin
        check("word_out_sb", 32'(word_out), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    RST_N               = 1'b0;
    scan_enable         = 1'b0;
    scan_shift_feedback = 1'b0;
    scan_chain          = 1'b0;
    word_ready          = 1'b1;
    #3;
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_out", 32'(word_out), 32'd0);
    check("rst_shift_busy", 32'(shift_busy), 32'd0);
    check("rst_partial_abort", 32'(partial_abort), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`ifdef SCAN_CAPTURE_HAMMING_EN
    check("rst_hdist", 32'(hamming_dist), 32'd0);
    check("rst_hacc", 32'(hamming_acc), 32'd0);
`endif
    tick();
    RST_N = 1'b1;
    tick();

    // A5C3, strobe every cycle, consumer always ready.
    sb_q.push_back(16'hA5C3);
    shift_bits(16'hA5C3, 15, 0);
    check("busy_mid_word", 32'(shift_busy), 32'd1);
    check("valid_before_last", 32'(word_valid), 32'd0);
    scan_enable = 1'b1; scan_shift_feedback = 1'b1; scan_chain = 1'b1; // bit 16 of A5C3
    tick();
    scan_shift_feedback = 1'b0;
    check("valid_latency", 32'(word_valid), 32'd1);
    check("word_a5c3", 32'(word_out), 32'hA5C3);
    check("busy_after_word", 32'(shift_busy), 32'd0);
    tick();
    check("valid_cleared", 32'(word_valid), 32'd0);

    // Full buffer: 1234 held, FFFF dropped.
    word_ready = 1'b0;
    sb_q.push_back(16'h1234);
    shift_bits(16'h1234, W, 0);
    shift_bits(16'hFFFF, W, 0);
    tick();
    check("hold_word", 32'(word_out), 32'h1234);
    check("hold_valid", 32'(word_valid), 32'd1);
    check("drop_cnt_1", 32'(drop_cnt), 32'd1);
    word_ready = 1'b1;
    tick();
    check("valid_after_drain", 32'(word_valid), 32'd0);

    // Abort after 7 bits, then a clean 00FF.
    shift_bits(16'hAB00, 7, 0);
    check("busy_before_abort", 32'(shift_busy), 32'd1);
    scan_enable = 1'b0;
    tick();
    check("abort_pulse", 32'(partial_abort), 32'd1);
    check("abort_busy", 32'(shift_busy), 32'd0);
    check("abort_valid_kept", 32'(word_valid), 32'd0);
    tick();
    check("abort_pulse_end", 32'(partial_abort), 32'd0);
    sb_q.push_back(16'h00FF);
    shift_bits(16'h00FF, W, 0);
    check("word_00ff", 32'(word_out), 32'h00FF);

    // Strobes with scan_enable low are ignored; no abort pulse from idle.
    scan_enable = 1'b0; scan_shift_feedback = 1'b1; scan_chain = 1'b1;
    repeat (3) tick();
    check("ignored_busy", 32'(shift_busy), 32'd0);
    check("idle_no_abort", 32'(partial_abort), 32'd0);
    scan_shift_feedback = 1'b0;

    // Strobe every third cycle.
    sb_q.push_back(16'h8001);
    shift_bits(16'h8001, W, 2);
    check("word_8001", 32'(word_out), 32'h8001);
    repeat (4) tick();

    // Back-to-back words.
    sb_q.push_back(16'hC0DE);
    sb_q.push_back(16'h1357);
    shift_bits(16'hC0DE, W, 0);
    shift_bits(16'h1357, W, 0);
    check("word_1357", 32'(word_out), 32'h1357);
    repeat (3) tick();

    // Async reset with a held word and a partial word in flight.
    word_ready = 1'b0;
    sb_q.push_back(16'h5A5A);
    shift_bits(16'h5A5A, W, 0);
    shift_bits(16'h3C3C, 10, 0);
    check("pre_rst_valid", 32'(word_valid), 32'd1);
    check("pre_rst_busy", 32'(shift_busy), 32'd1);
    #2;
    RST_N = 1'b0;
    sb_q.delete();
    #1;
    check("arst_valid", 32'(word_valid), 32'd0);
    check("arst_word", 32'(word_out), 32'd0);
    check("arst_busy", 32'(shift_busy), 32'd0);
    check("arst_drop", 32'(drop_cnt), 32'd0);
    scan_enable = 1'b0;
    tick();
    RST_N = 1'b1;
    word_ready = 1'b1;
    tick();
    sb_q.push_back(16'h0F0F);
    shift_bits(16'h0F0F, W, 0);
    check("post_rst_word", 32'(word_out), 32'h0F0F);
    repeat (3) tick();

`ifdef SCAN_CAPTURE_HAMMING_EN
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    sb_q.push_back(16'h0000);
    sb_q.push_back(16'h000F);
    sb_q.push_back(16'hF00F);
    shift_bits(16'h0000, W, 0);
    check("hdist_0", 32'(hamming_dist), 32'd0);
    shift_bits(16'h000F, W, 0);
    check("hdist_1", 32'(hamming_dist), 32'd4);
    shift_bits(16'hF00F, W, 0);
    check("hdist_2", 32'(hamming_dist), 32'd4);
    check("hacc", 32'(hamming_acc), 32'd8);
    repeat (3) tick();
`endif

    scan_enable = 1'b0;
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
